i2c_nios_pio_in: RTL and testbench



---
 rtl/i2c_nios_pio_in.sv | 158 +++++++++++++++
 tb/tb_i2c_nios_pio_in.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_nios_pio_in.sv
// i2c_nios_pio_in
// Avalon-MM input PIO: two-flop synchroniser, optional tick-based debounce
// filter, per-bit edge capture with write-1-to-clear, and a level interrupt
// raised while any captured edge is unmasked.
module i2c_nios_pio_in #(
    parameter int          WIDTH              = 8,
    parameter int          EDGE_TYPE          = 0,
    parameter int          DEBOUNCE_SAMPLES   = 4,
    parameter logic [15:0] DEBOUNCE_DIV_RESET = 16'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SAMPLES - 1);

    localparam logic [1:0] ADDR_DB      = 2'd0;
    localparam logic [1:0] ADDR_DIV     = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Register state
    logic [WIDTH-1:0]      r_s1;
    logic [WIDTH-1:0]      r_s2;
    logic [WIDTH-1:0]      r_db;
    logic [WIDTH-1:0][3:0] r_cnt;
    logic [15:0]           r_pre;
    logic [15:0]           r_div;
    logic [WIDTH-1:0]      r_mask;
    logic [WIDTH-1:0]      r_cap;

    // Next-state and decode
    logic                  w_wr;
    logic                  w_wr_div;
    logic                  w_wr_mask;
    logic                  w_wr_cap;
    logic                  w_filter;
    logic                  w_tick;
    logic [15:0]           w_pre_next;
    logic [WIDTH-1:0]      w_db_next;
    logic [WIDTH-1:0][3:0] w_cnt_next;
    logic [WIDTH-1:0]      w_rise;
    logic [WIDTH-1:0]      w_fall;
    logic [WIDTH-1:0]      w_set;
    logic [WIDTH-1:0]      w_clr;
    logic                  w_unused_writedata;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_div  = w_wr && (address == ADDR_DIV);
    assign w_wr_mask = w_wr && (address == ADDR_MASK);
    assign w_wr_cap  = w_wr && (address == ADDR_EDGECAP);

    // A zero divider bypasses the filter entirely.
    assign w_filter  = (r_div != 16'd0);
    assign w_tick    = w_filter && (r_pre == r_div);

    // Upper writedata bits are not stored for narrow buses.
    assign w_unused_writedata = ^writedata;

    // Prescaler next value: idle at zero in bypass, restarted by a divider write.
    always_comb begin
        w_pre_next = 16'd0;
        if (!w_wr_div && w_filter && !w_tick) begin
            w_pre_next = r_pre + 16'd1;
        end
    end

    // Filtered level and per-bit debounce counters.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_db_next  = r_db;
        w_cnt_next = r_cnt;
        if (w_wr_div) begin
            // Divider write restarts filtering from a clean count; level holds.
            w_cnt_next = '0;
        end else if (!w_filter) begin
            w_db_next  = r_s2;
            w_cnt_next = '0;
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    w_cnt_next[i] = 4'd0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_db_next[i]  = r_s2[i];
                    w_cnt_next[i] = 4'd0;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Edge selection from the level change happening this cycle.
    always_comb begin
        w_rise = ~r_db & w_db_next;
        w_fall = r_db & ~w_db_next;
        if (EDGE_TYPE == 0) begin
            w_set = w_rise;
        end else if (EDGE_TYPE == 1) begin
            w_set = w_fall;
        end else begin
            w_set = w_rise | w_fall;
        end
        w_clr = w_wr_cap ? writedata[WIDTH-1:0] : '0;
    end

    // Sequential state, including the synchroniser and the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            // NOTE: the counter array is small per-bit state, not a RAM, so it is reset with everything else.
            r_cnt  <= '0;
            r_pre  <= 16'd0;
            r_div  <= DEBOUNCE_DIV_RESET;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values (s2 takes the old s1).
            r_s1  <= in_port;
            r_s2  <= r_s1;
            r_db  <= w_db_next;
            r_cnt <= w_cnt_next;
            r_pre <= w_pre_next;
            // Set is ORed in after the clear so a simultaneous edge survives.
            r_cap <= (r_cap & ~w_clr) | w_set;
            if (w_wr_div) begin
                r_div <= writedata[15:0];
            end
            if (w_wr_mask) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DB:      readdata[WIDTH-1:0] = r_db;
            ADDR_DIV:     readdata[15:0]      = r_div;
            ADDR_MASK:    readdata[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = r_cap;
            default:      readdata            = 32'd0;
        endcase
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_i2c_nios_pio_in.sv
// Testbench for i2c_nios_pio_in: two instances (rising-only and any-edge)
// share one bus and are compared every cycle against a behavioural model,
// plus directed checks of the documented timing and corner cases.
module tb_i2c_nios_pio_in;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata0;
    logic [31:0] readdata2;
    logic        irq0;
    logic        irq2;

    int n_vec;
    int n_err;

    i2c_nios_pio_in #(
        .WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_SAMPLES(4), .DEBOUNCE_DIV_RESET(16'd0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata0), .irq(irq0)
    );

    i2c_nios_pio_in #(
        .WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_SAMPLES(4), .DEBOUNCE_DIV_RESET(16'd0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [7:0]  m_s1, m_s2, m_db, m_mask, m_cap0, m_cap2;
    logic [15:0] m_div;
    int          m_pre;
    int          m_cnt [8];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_mask = 0; m_cap0 = 0; m_cap2 = 0;
        m_div = 16'd0; m_pre = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    // One clock edge worth of behaviour, taken from the register rules.
    task automatic model_update();
        bit         wr;
        logic [7:0] dbn, rise, fall, clr;
        int         cntn [8];
        int         pren;
        if (reset) begin
            model_reset();
        end else begin
            wr   = chipselect && !write_n;
            dbn  = m_db;
            pren = 0;
            for (int i = 0; i < 8; i++) cntn[i] = m_cnt[i];
            if (wr && address == 2'd1) begin
                for (int i = 0; i < 8; i++) cntn[i] = 0;
            end else if (m_div == 0) begin
                dbn = m_s2;
                for (int i = 0; i < 8; i++) cntn[i] = 0;
            end else if (m_pre == int'(m_div)) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_s2[i] == m_db[i]) cntn[i] = 0;
                    else if (m_cnt[i] == 3) begin dbn[i] = m_s2[i]; cntn[i] = 0; end
                    else cntn[i] = m_cnt[i] + 1;
                end
            end else begin
                pren = m_pre + 1;
            end
            rise   = ~m_db & dbn;
            fall   = m_db & ~dbn;
            clr    = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
            m_cap0 = (m_cap0 & ~clr) | rise;
            m_cap2 = (m_cap2 & ~clr) | rise | fall;
            if (wr && address == 2'd2) m_mask = writedata[7:0];
            if (wr && address == 2'd1) m_div = writedata[15:0];
            m_s2  = m_s1;
            m_s1  = in_port;
            m_db  = dbn;
            m_pre = pren;
            for (int i = 0; i < 8; i++) m_cnt[i] = cntn[i];
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input bit any_edge);
        case (a)
            2'd0:    return {24'd0, m_db};
            2'd1:    return {16'd0, m_div};
            2'd2:    return {24'd0, m_mask};
            default: return {24'd0, any_edge ? m_cap2 : m_cap0};
        endcase
    endfunction

    // Compare outputs against the model, then advance one clock (ends at negedge).
    task automatic step();
        logic [31:0] e0, e2;
        bit          ei0, ei2;
        #1;
        e0  = exp_rd(address, 1'b0);
        e2  = exp_rd(address, 1'b1);
        ei0 = |(m_cap0 & m_mask);
        ei2 = |(m_cap2 & m_mask);
        n_vec++;
        if (readdata0 !== e0) begin n_err++; $display("FAIL model_rd0 addr=%0d got=%h exp=%h t=%0t", address, readdata0, e0, $time); end
        n_vec++;
        if (readdata2 !== e2) begin n_err++; $display("FAIL model_rd2 addr=%0d got=%h exp=%h t=%0t", address, readdata2, e2, $time); end
        n_vec++;
        if (irq0 !== ei0) begin n_err++; $display("FAIL model_irq0 got=%b exp=%b t=%0t", irq0, ei0, $time); end
        n_vec++;
        if (irq2 !== ei2) begin n_err++; $display("FAIL model_irq2 got=%b exp=%b t=%0t", irq2, ei2, $time); end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            n_vec++;
            if (readdata0 !== 32'd0 || readdata2 !== 32'd0) begin
                n_err++; $display("FAIL reset_read addr=%0d got=%h/%h exp=00000000", a, readdata0, readdata2);
            end
        end
        n_vec++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b/%b exp=0", irq0, irq2); end
        address = 2'd0;
        step(); step();
        reset = 1'b0;
        step(); step();
    endtask

    task automatic test_bypass_rise();
        do_write(2'd2, 32'h01);
        in_port = 8'h01;
        address = 2'd0;
        step(); step();
        #1; n_vec++;
        if (readdata0 !== 32'h0) begin n_err++; $display("FAIL bypass_db_early got=%h exp=%h", readdata0, 32'h0); end
        step();
        #1; n_vec++;
        if (readdata0 !== 32'h1) begin n_err++; $display("FAIL bypass_db_3edges got=%h exp=%h", readdata0, 32'h1); end
        address = 2'd3; #1; n_vec++;
        if (readdata0 !== 32'h1) begin n_err++; $display("FAIL bypass_edgecap got=%h exp=%h", readdata0, 32'h1); end
        n_vec++;
        if (irq0 !== 1'b1) begin n_err++; $display("FAIL bypass_irq_set got=%b exp=1", irq0); end
        do_write(2'd3, 32'h01);
        #1; n_vec++;
        if (irq0 !== 1'b0) begin n_err++; $display("FAIL bypass_irq_clear got=%b exp=0", irq0); end
        in_port = 8'h00;
        address = 2'd3;
        repeat (4) step();
        #1; n_vec++;
        if (readdata0 !== 32'h0) begin n_err++; $display("FAIL bypass_fall_ignored got=%h exp=%h", readdata0, 32'h0); end
        n_vec++;
        if (readdata2 !== 32'h1) begin n_err++; $display("FAIL anyedge_fall_bit0 got=%h exp=%h", readdata2, 32'h1); end
    endtask

    task automatic test_any_edge_set_wins();
        do_write(2'd2, 32'hFF);
        do_write(2'd3, 32'hFF);
        in_port = 8'h80;
        address = 2'd3;
        repeat (3) step();
        #1; n_vec++;
        if (readdata2 !== 32'h80) begin n_err++; $display("FAIL anyedge_rise got=%h exp=%h", readdata2, 32'h80); end
        n_vec++;
        if (irq2 !== 1'b1) begin n_err++; $display("FAIL anyedge_irq got=%b exp=1", irq2); end
        do_write(2'd3, 32'h80);
        #1; n_vec++;
        if (readdata2 !== 32'h0) begin n_err++; $display("FAIL anyedge_cleared got=%h exp=%h", readdata2, 32'h0); end
        in_port = 8'h00;
        step(); step();
        do_write(2'd3, 32'h80);
        address = 2'd3;
        #1; n_vec++;
        if (readdata2 !== 32'h80) begin n_err++; $display("FAIL set_wins got=%h exp=%h", readdata2, 32'h80); end
        do_write(2'd3, 32'hFF);
    endtask

    task automatic test_filter();
        do_write(2'd1, 32'd3);
        address = 2'd0;
        // s2 is high for 12 consecutive cycles spanning exactly three ticks.
        for (int j = 1; j <= 22; j++) begin
            in_port = (j >= 3 && j <= 14) ? 8'h0F : 8'h00;
            step();
        end
        #1; n_vec++;
        if (readdata0 !== 32'h0) begin n_err++; $display("FAIL filter_short_reject got=%h exp=%h", readdata0, 32'h0); end
        address = 2'd3; #1; n_vec++;
        if (readdata2 !== 32'h0) begin n_err++; $display("FAIL filter_short_nocap got=%h exp=%h", readdata2, 32'h0); end
        address = 2'd0;
        in_port = 8'h0F;
        repeat (12) step();
        #1; n_vec++;
        if (readdata0 !== 32'h0) begin n_err++; $display("FAIL filter_not_before_4th got=%h exp=%h", readdata0, 32'h0); end
        repeat (8) step();
        #1; n_vec++;
        if (readdata0 !== 32'h0F) begin n_err++; $display("FAIL filter_level_accept got=%h exp=%h", readdata0, 32'h0F); end
        do_write(2'd3, 32'hFF);
    endtask

    task automatic test_glitch();
        do_write(2'd1, 32'd9);
        address = 2'd0;
        // Ticks fall on cycles 10 and 20; the glitch reaches s2 on cycles 13-14.
        for (int j = 1; j <= 25; j++) begin
            in_port = (j == 11 || j == 12) ? 8'h8F : 8'h0F;
            step();
        end
        #1; n_vec++;
        if (readdata0 !== 32'h0F) begin n_err++; $display("FAIL glitch_db got=%h exp=%h", readdata0, 32'h0F); end
        address = 2'd3; #1; n_vec++;
        if (readdata0 !== 32'h0 || readdata2 !== 32'h0) begin
            n_err++; $display("FAIL glitch_edgecap got=%h/%h exp=00000000", readdata0, readdata2);
        end
    endtask

    task automatic test_registers_and_reset();
        do_write(2'd1, 32'h1234);
        do_write(2'd2, 32'hA5);
        address = 2'd1; #1; n_vec++;
        if (readdata0 !== 32'h00001234) begin n_err++; $display("FAIL div_readback got=%h exp=%h", readdata0, 32'h1234); end
        address = 2'd2; #1; n_vec++;
        if (readdata0 !== 32'h000000A5) begin n_err++; $display("FAIL mask_readback got=%h exp=%h", readdata0, 32'hA5); end
        do_write(2'd0, 32'hFFFF_FFFF);
        address = 2'd0; #1; n_vec++;
        if (readdata0 !== 32'h0F) begin n_err++; $display("FAIL db_write_ignored got=%h exp=%h", readdata0, 32'h0F); end
        do_write(2'd1, 32'd2);
        in_port = 8'hF0;
        repeat (7) step();
        reset = 1'b1;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); #1; n_vec++;
            if (readdata0 !== 32'd0 || readdata2 !== 32'd0) begin
                n_err++; $display("FAIL midreset_read addr=%0d got=%h/%h exp=00000000", a, readdata0, readdata2);
            end
        end
        n_vec++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_err++; $display("FAIL midreset_irq got=%b/%b exp=0", irq0, irq2); end
        in_port = 8'hFF;
        address = 2'd3;
        step(); step();
        reset = 1'b0;
        step(); step();
        #1; n_vec++;
        if (readdata0 !== 32'h0) begin n_err++; $display("FAIL release_early got=%h exp=%h", readdata0, 32'h0); end
        step();
        #1; n_vec++;
        if (readdata0 !== 32'hFF) begin n_err++; $display("FAIL release_rise got=%h exp=%h", readdata0, 32'hFF); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = 8'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 9) != 0);
            address    = 2'($urandom);
            if (chipselect && !write_n && address == 2'd1) writedata = $urandom_range(0, 3);
            else writedata = $urandom;
            step();
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_bypass_rise();
        test_any_edge_set_wins();
        test_filter();
        test_glitch();
        test_registers_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
